// File: rtl/alu_pkg.sv
// Definitions shared by the sequencer and the ALU: opcodes, instruction fields, state encoding.
package alu_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam int OPC_HI     = 31;
    localparam int OPC_LO     = 26;
    localparam int RD_HI      = 25;
    localparam int RD_LO      = 23;
    localparam int RS1_HI     = 22;
    localparam int RS1_LO     = 20;
    localparam int RS2_HI     = 19;
    localparam int RS2_LO     = 17;
    localparam int IMMSEL_BIT = 16;
    localparam int IMM_HI     = 15;
    localparam int IMM_LO     = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // HALT is handled by the sequencer itself, so it is not a retiring opcode.
    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two decode read ports, one debug read port, one synchronous write port.
// r0 always reads zero and ignores writes.
module alu_regfile #(
    parameter int REGS = 8,
    parameter int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   rdata1,
    output logic [31:0]   rdata2,
    output logic [31:0]   dbg_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    logic [31:0] mem [REGS];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < REGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue sequencer feeding an external combinational ALU and retiring results to the register file.
//   state        | meaning
//   ST_IDLE      | ready for an instruction word
//   ST_DECODE    | read operands, register ALU inputs
//   ST_EXECUTE   | capture ALU result
//   ST_WRITEBACK | write R[rd], pulse wbValid
//   ST_HALT      | HALT retired, parked until reset
module alu_sequencer #(
    parameter int REGS = 8,
    parameter int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          instrValid,
    input  logic [31:0]   instrData,
    output logic          instrReady,
    output logic [31:0]   aluOperand1,
    output logic [31:0]   aluOperand2,
    output logic [5:0]    aluOpCode,
    input  logic [31:0]   aluResult,
    output logic          wbValid,
    output logic [AW-1:0] wbAddr,
    output logic [31:0]   wbData,
    output logic          illegal,
    output logic          halted,
    input  logic [AW-1:0] dbgAddr,
    output logic [31:0]   dbgData
);
    import alu_pkg::*;

    state_t        state, state_nxt;
    logic [31:0]   instr_q;
    logic [31:0]   result_q;
    logic [31:0]   rd1, rd2;
    logic [5:0]    opc;
    logic [AW-1:0] rd, rs1, rs2;
    logic          rf_we;
    logic          legal;

    assign opc   = instr_q[OPC_HI:OPC_LO];
    assign rd    = instr_q[RD_HI:RD_LO];
    assign rs1   = instr_q[RS1_HI:RS1_LO];
    assign rs2   = instr_q[RS2_HI:RS2_LO];
    assign legal = op_is_legal(opc);

    alu_regfile #(.REGS(REGS), .AW(AW)) u_regfile (
        .clk      (clk),
        .rstN     (rstN),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .dbg_addr (dbgAddr),
        .rdata1   (rd1),
        .rdata2   (rd2),
        .dbg_data (dbgData),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (result_q)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // ALU inputs are only reloaded in DECODE so they hold across IDLE.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            instr_q     <= '0;
            aluOperand1 <= '0;
            aluOperand2 <= '0;
            aluOpCode   <= '0;
            result_q    <= '0;
        end else begin
            if (state == ST_IDLE && instrValid) instr_q <= instrData;
            if (state == ST_DECODE) begin
                aluOperand1 <= rd1;
                aluOperand2 <= instr_q[IMMSEL_BIT] ? {16'b0, instr_q[IMM_HI:IMM_LO]} : rd2;
                aluOpCode   <= opc;
            end
            if (state == ST_EXECUTE) result_q <= aluResult;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (instrValid) state_nxt = ST_DECODE;
            ST_DECODE:    state_nxt = (opc == OP_HALT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_nxt = ST_WRITEBACK;
            ST_WRITEBACK: state_nxt = ST_IDLE;
            ST_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        instrReady = (state == ST_IDLE);
        halted     = (state == ST_HALT);
        wbValid    = 1'b0;
        wbAddr     = '0;
        wbData     = '0;
        illegal    = 1'b0;
        rf_we      = 1'b0;
        if (state == ST_WRITEBACK) begin
            wbValid = 1'b1;
            wbAddr  = rd;
            wbData  = legal ? result_q : '0;
            illegal = !legal;
            rf_we   = legal;
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Single-issue instruction sequencer that drives the team's combinational ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes the opcode and register fields. It reads operands from an internal 8×32 register file, presents them with the opcode to the ALU, and captures and writes back the ALU result. It sits between the instruction source (a fetch unit or test bench) and the existing ALU, which stays a separate combinational instance.

## Interface
Parameters:
- `REGS`, 8: register-file depth. Index width is log2(REGS) = 3. Register r0 reads as zero.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `instrValid` input 1: instruction word offered.
- `instrData` input 32: instruction word.
- `instrReady` output 1: sequencer can accept an instruction.
- `aluOperand1` output 32: ALU operand 1.
- `aluOperand2` output 32: ALU operand 2.
- `aluOpCode` output 6: ALU opcode.
- `aluResult` input 32: combinational ALU result.
- `wbValid` output 1: one-cycle pulse when an instruction retires.
- `wbAddr` output 3: destination register of the retiring instruction.
- `wbData` output 32: value written.
- `illegal` output 1: qualifies `wbValid`; the retiring instruction had an unsupported opcode.
- `halted` output 1: HALT executed. Held until reset.
- `dbgAddr` input 3: debug read index.
- `dbgData` output 32: combinational read of register `dbgAddr`.

## Operation
Instruction format:
- [31:26] opcode.
- [25:23] rd.
- [22:20] rs1.
- [19:17] rs2.
- [16] immSel.
- [15:0] imm, zero-extended to 32 bits.

Opcodes:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, HALT=63.
- Any other value is illegal.

Operands:
- operand1 = R[rs1].
- operand2 = immSel ? zext(imm) : R[rs2].
- Reads of r0 return 0.
- Writes to r0 are discarded, but `wbValid` still pulses and `wbAddr` = 0.

State machine (IDLE, DECODE, EXECUTE, WRITEBACK, HALT):
- IDLE: `instrReady`=1. On `instrValid`&&`instrReady`, latch `instrData` and go to DECODE.
- DECODE: read the register file and register the operand and opcode outputs. HALT opcode goes to HALT; otherwise go to EXECUTE.
- EXECUTE: sample `aluResult` into the result register and go to WRITEBACK.
- WRITEBACK: write R[rd] and pulse `wbValid` for one cycle, then return to IDLE.
  - Illegal opcode: no register write, `illegal`=1, `wbData`=0.
- HALT: `halted`=1 and `instrReady`=0. Stays in HALT until `rstN` is asserted low; `instrValid` is ignored.

Other rules:
- ALU outputs hold their values from DECODE until the next DECODE; they do not return to 0 in IDLE.
- All arithmetic is 32-bit modulo 2^32, with no carry or overflow flags. This is inherited from the ALU.
- Operands are read in DECODE, so there are no hazards: the previous write completes in its WRITEBACK cycle.

## Timing
- Handshake fires on the rising edge at cycle N.
  - DECODE at N+1, ALU outputs valid from N+2.
  - EXECUTE at N+2.
  - `wbValid` high during N+3; the register file is updated at the end of N+3.
  - `instrReady` high again at N+4.
- Throughput is one instruction per 4 cycles.
- `instrReady` is a pure function of state (IDLE) and does not depend on `instrValid`.
- Register file write timing: a `dbgAddr` read during WRITEBACK returns the old value; it returns the new value from N+4.
- Reset (asynchronous, any state including mid-instruction):
  - State goes to IDLE and any in-flight instruction is discarded with no write.
  - All registers R0..R7 = 0.
  - `aluOperand1`/`aluOperand2` = 0, `aluOpCode` = 0.
  - `wbValid`, `wbAddr`, `wbData`, `illegal`, `halted` = 0.
  - `instrReady` = 1 on the first cycle after reset release.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants (ADD, SUB, AND, OR, XOR, HALT), shared with the ALU.
  - Instruction field bit positions.
  - The state encoding.
- Sub-module `alu_regfile` provides:
  - 8×32 storage.
  - Two decode read ports and the debug read port, all combinational.
  - One synchronous write port.
  - r0 behaviour (reads 0, writes discarded) and asynchronous reset.
- The ALU is instantiated beside this block at the top level, not inside it.

## Test plan
- Reset, then ADD r1 = r0 + imm 5, then ADD r2 = r1 + imm 7 → `wbData` 5 then 12, `wbValid` at N+3, `dbgData`(r2)=12.
- SUB r3 = r1 − r2 with r1=5, r2=12 → `wbData`=0xFFFFFFF9. Then XOR r4 = r3 ^ imm 0xFFFF → 0xFFFF0006.
- Opcode 6 → `wbValid`&&`illegal`, registers unchanged. Write to r0 → `dbgData`(0)=0.
- `instrValid` held high continuously → exactly one accept per 4 cycles; `instrReady` low during DECODE, EXECUTE and WRITEBACK.
- HALT → `halted`=1, `instrReady`=0, and further instructions are ignored for 20 cycles. Then assert `rstN` low → all outputs 0, `instrReady`=1 after release.
- Assert `rstN` low during EXECUTE of ADD r5 = imm 9 → no `wbValid`, r5=0 after reset.
